// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline tracking / stall controller.
// Holds opcode and funct encodings, instruction field positions, and the
// Tuse sentinel used by instructions that never read a source register.
package hazard_pipe_ctrl_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_JAL   = 6'h03;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  // Field bit ranges
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  // A source that is never read gets a Tuse no Tnew can exceed.
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [4:0]  REG_RA    = 5'd31;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Tnew one stage later, saturating at zero.
  function automatic logic [1:0] tnew_step(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_pipe_ctrl_decode.sv
// instr_decode_t: combinational per-instruction hazard attributes.
// Ports: instr in; a3 (destination reg), tuse_rs, tuse_rt, tnew0 (Tnew on
// entry to E) out. Unrecognised encodings decode like a NOP (a3 = 0).
module instr_decode_t
  import hazard_pipe_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  a3,
  output logic [1:0]  tuse_rs,
  output logic [1:0]  tuse_rt,
  output logic [1:0]  tnew0
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;

  // rs and shamt carry no information about the destination or timing.
  logic [9:0] unused_fields;

  assign op = instr[OP_HI:OP_LO];
  assign fn = instr[FN_HI:FN_LO];
  assign rt = instr[RT_HI:RT_LO];
  assign rd = instr[RD_HI:RD_LO];
  assign unused_fields = {instr[RS_HI:RS_LO], instr[10:6]};

  always_comb begin
    a3      = 5'd0;
    tuse_rs = TUSE_NONE;
    tuse_rt = TUSE_NONE;
    tnew0   = 2'd0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADDU, FN_SUBU: begin
            a3      = rd;
            tuse_rs = 2'd1;
            tuse_rt = 2'd1;
            tnew0   = 2'd1;
          end
          FN_JR:   tuse_rs = 2'd0;
          default: ;
        endcase
      end
      OP_ORI: begin
        a3      = rt;
        tuse_rs = 2'd1;
        tnew0   = 2'd1;
      end
      OP_LW: begin
        a3      = rt;
        tuse_rs = 2'd1;
        tnew0   = 2'd2;
      end
      OP_LUI:  a3 = rt;
      OP_JAL:  a3 = REG_RA;
      OP_SW: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      OP_BEQ: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: carries instr/pc through D, E, M, W and raises stall on
// RAW hazards the forwarding network cannot resolve (Tnew > Tuse in E or M).
// Ports: clk, reset_n; instrF/pcF in; stall, pc_en, instr*/pc*, tnewE/M out.
module hazard_pipe_ctrl
  import hazard_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_3000,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instrF,
  input  logic [31:0] pcF,
  output logic        stall,
  output logic        pc_en,
  output logic [31:0] instrD,
  output logic [31:0] instrE,
  output logic [31:0] instrM,
  output logic [31:0] instrW,
  output logic [31:0] pcD,
  output logic [31:0] pcE,
  output logic [31:0] pcM,
  output logic [31:0] pcW,
  output logic [1:0]  tnewE,
  output logic [1:0]  tnewM
);

  logic [31:0] instr_d_q, instr_e_q, instr_m_q, instr_w_q;
  logic [31:0] instr_d_d, instr_e_d, instr_m_d, instr_w_d;
  logic [31:0] pc_d_q, pc_e_q, pc_m_q, pc_w_q;
  logic [31:0] pc_d_d, pc_e_d, pc_m_d, pc_w_d;
  logic [1:0]  tnew_e_q, tnew_m_q;
  logic [1:0]  tnew_e_d, tnew_m_d;

  // D supplies the consumer view, E and M only their destination register.
  logic [4:0] a3_d_unused, a3_e, a3_m;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew0_d;
  logic [1:0] tuse_rs_e_unused, tuse_rt_e_unused, tnew0_e_unused;
  logic [1:0] tuse_rs_m_unused, tuse_rt_m_unused, tnew0_m_unused;

  instr_decode_t u_dec_d (
    .instr   (instr_d_q),
    .a3      (a3_d_unused),
    .tuse_rs (tuse_rs_d),
    .tuse_rt (tuse_rt_d),
    .tnew0   (tnew0_d)
  );

  instr_decode_t u_dec_e (
    .instr   (instr_e_q),
    .a3      (a3_e),
    .tuse_rs (tuse_rs_e_unused),
    .tuse_rt (tuse_rt_e_unused),
    .tnew0   (tnew0_e_unused)
  );

  instr_decode_t u_dec_m (
    .instr   (instr_m_q),
    .a3      (a3_m),
    .tuse_rs (tuse_rs_m_unused),
    .tuse_rt (tuse_rt_m_unused),
    .tnew0   (tnew0_m_unused)
  );

  logic [4:0] rs_d, rt_d;
  logic       haz_rs_e, haz_rt_e, haz_rs_m, haz_rt_m;

  assign rs_d = instr_d_q[RS_HI:RS_LO];
  assign rt_d = instr_d_q[RT_HI:RT_LO];

  // $0 is hard-wired, so a match on it is never a real dependence.
  // W is never checked: its result is always available via the register file.
  assign haz_rs_e = (rs_d != 5'd0) && (rs_d == a3_e) && (tnew_e_q > tuse_rs_d);
  assign haz_rt_e = (rt_d != 5'd0) && (rt_d == a3_e) && (tnew_e_q > tuse_rt_d);
  assign haz_rs_m = (rs_d != 5'd0) && (rs_d == a3_m) && (tnew_m_q > tuse_rs_d);
  assign haz_rt_m = (rt_d != 5'd0) && (rt_d == a3_m) && (tnew_m_q > tuse_rt_d);

  assign stall = haz_rs_e | haz_rt_e | haz_rs_m | haz_rt_m;
  assign pc_en = ~stall;

  always_comb begin
    instr_d_d = instrF;
    pc_d_d    = pcF;
    instr_e_d = instr_d_q;
    pc_e_d    = pc_d_q;
    tnew_e_d  = tnew0_d;
    instr_m_d = instr_e_q;
    pc_m_d    = pc_e_q;
    tnew_m_d  = tnew_step(tnew_e_q);
    instr_w_d = instr_m_q;
    pc_w_d    = pc_m_q;
    if (stall) begin
      // Freeze D; the bubble in E borrows pcD so it still carries a valid PC.
      instr_d_d = instr_d_q;
      pc_d_d    = pc_d_q;
      instr_e_d = NOP;
      tnew_e_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_d_q <= NOP;
      instr_e_q <= NOP;
      instr_m_q <= NOP;
      instr_w_q <= NOP;
      pc_d_q    <= PC_INIT;
      pc_e_q    <= PC_INIT;
      pc_m_q    <= PC_INIT;
      pc_w_q    <= PC_INIT;
      tnew_e_q  <= 2'd0;
      tnew_m_q  <= 2'd0;
    end else begin
      instr_d_q <= instr_d_d;
      instr_e_q <= instr_e_d;
      instr_m_q <= instr_m_d;
      instr_w_q <= instr_w_d;
      pc_d_q    <= pc_d_d;
      pc_e_q    <= pc_e_d;
      pc_m_q    <= pc_m_d;
      pc_w_q    <= pc_w_d;
      tnew_e_q  <= tnew_e_d;
      tnew_m_q  <= tnew_m_d;
    end
  end

  assign instrD = instr_d_q;
  assign instrE = instr_e_q;
  assign instrM = instr_m_q;
  assign instrW = instr_w_q;
  assign pcD    = pc_d_q;
  assign pcE    = pc_e_q;
  assign pcM    = pc_m_q;
  assign pcW    = pc_w_q;
  assign tnewE  = tnew_e_q;
  assign tnewM  = tnew_m_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Bench for hazard_pipe_ctrl: small program ROM fetched by a PC that honours
// pc_en; per-cycle stall/Tnew expectations and the W retirement stream are
// queued up front and consumed by an independent monitor.
module tb_hazard_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instrF, pcF;
  logic        stall, pc_en;
  logic [31:0] instrD, instrE, instrM, instrW;
  logic [31:0] pcD, pcE, pcM, pcW;
  logic [1:0]  tnewE, tnewM;

  always #5 clk = ~clk;

  hazard_pipe_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .instrF  (instrF),
    .pcF     (pcF),
    .stall   (stall),
    .pc_en   (pc_en),
    .instrD  (instrD),
    .instrE  (instrE),
    .instrM  (instrM),
    .instrW  (instrW),
    .pcD     (pcD),
    .pcE     (pcE),
    .pcM     (pcM),
    .pcW     (pcW),
    .tnewE   (tnewE),
    .tnewM   (tnewM)
  );

  // Instruction encodings
  localparam logic [31:0] I_LW1     = 32'h8c01_0000; // lw   $1,0($0)
  localparam logic [31:0] I_ADDU211 = 32'h0021_1021; // addu $2,$1,$1
  localparam logic [31:0] I_BEQ10   = 32'h1020_0000; // beq  $1,$0,0
  localparam logic [31:0] I_ORI3    = 32'h3403_0005; // ori  $3,$0,5
  localparam logic [31:0] I_JR3     = 32'h0060_0008; // jr   $3
  localparam logic [31:0] I_ADDU430 = 32'h0060_2021; // addu $4,$3,$0
  localparam logic [31:0] I_LW0     = 32'h8c00_0000; // lw   $0,0($0)
  localparam logic [31:0] I_ADDU200 = 32'h0000_1021; // addu $2,$0,$0
  localparam logic [31:0] I_LW5     = 32'h8c05_0000; // lw   $5,0($0)
  localparam logic [31:0] I_SW56    = 32'hacc5_0000; // sw   $5,0($6)
  localparam logic [31:0] I_JAL     = 32'h0c00_0000; // jal  0
  localparam logic [31:0] I_JR31    = 32'h03e0_0008; // jr   $31

  // Fetch model
  logic [31:0] rom [0:7];
  logic [31:0] bpc;
  logic [31:0] idx;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bpc <= 32'h3000;
    else if (pc_en) bpc <= bpc + 32'd4;
  end

  always_comb begin
    idx    = (bpc - 32'h3000) >> 2;
    instrF = (idx < 32'd8) ? rom[idx[2:0]] : 32'h0;
    pcF    = bpc;
  end

  // Scoreboard
  typedef struct packed {
    logic       stall;
    logic [1:0] te;
    logic [1:0] tm;
  } cyc_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ret_t;

  cyc_t cyc_q[$];
  ret_t ret_q[$];
  cyc_t ce;
  ret_t re;
  int   total = 0;
  int   bad   = 0;
  int   kcyc  = 0;
  bit   mon_en = 1'b0;

  task automatic push_c(input logic s, input logic [1:0] te, input logic [1:0] tm);
    cyc_q.push_back(cyc_t'{stall: s, te: te, tm: tm});
  endtask

  task automatic push_r(input logic [31:0] instr, input logic [31:0] pc);
    ret_q.push_back(ret_t'{instr: instr, pc: pc});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Monitor: one cycle expectation per cycle, one retire per non-NOP in W.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (cyc_q.size() > 0) begin
          ce = cyc_q.pop_front();
          total++;
          if (stall !== ce.stall || pc_en !== ~ce.stall || tnewE !== ce.te || tnewM !== ce.tm) begin
            bad++;
            $display("FAIL cycle k=%0d: got stall=%b pc_en=%b tnewE=%0d tnewM=%0d want stall=%b pc_en=%b tnewE=%0d tnewM=%0d",
                     kcyc, stall, pc_en, tnewE, tnewM, ce.stall, ~ce.stall, ce.te, ce.tm);
          end
        end
        if (instrW !== 32'h0) begin
          total++;
          if (ret_q.size() == 0) begin
            bad++;
            $display("FAIL retire k=%0d: got unexpected instrW=%h pcW=%h want none", kcyc, instrW, pcW);
          end else begin
            re = ret_q.pop_front();
            if (instrW !== re.instr || pcW !== re.pc) begin
              bad++;
              $display("FAIL retire k=%0d: got instrW=%h pcW=%h want instrW=%h pcW=%h",
                       kcyc, instrW, pcW, re.instr, re.pc);
            end
          end
        end
        kcyc++;
      end
    end
  end

  task automatic load(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] i2);
    for (int i = 0; i < 8; i++) rom[i] = 32'h0;
    rom[0] = i0;
    rom[1] = i1;
    rom[2] = i2;
  endtask

  task automatic run_test(input string name);
    int waited;
    @(negedge clk);
    reset_n = 1'b1;
    kcyc    = 0;
    mon_en  = 1'b1;
    waited  = 0;
    while ((cyc_q.size() > 0 || ret_q.size() > 0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    total++;
    if (cyc_q.size() != 0 || ret_q.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got pending cyc=%0d ret=%0d want 0 0", name, cyc_q.size(), ret_q.size());
    end
    cyc_q.delete();
    ret_q.delete();
    reset_n = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    load(I_LW1, I_ADDU211, 32'h0);
    repeat (2) @(negedge clk);

    // Reset values, reset asserted mid-stall, first fetch after release
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst pc_en", {31'd0, pc_en}, 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("pre-reset stall", {31'd0, stall}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midstall stall", {31'd0, stall}, 32'd0);
    chk("midstall pc_en", {31'd0, pc_en}, 32'd1);
    chk("midstall instrD", instrD, 32'h0);
    chk("midstall instrE", instrE, 32'h0);
    chk("midstall instrM", instrM, 32'h0);
    chk("midstall instrW", instrW, 32'h0);
    chk("midstall pcD", pcD, 32'h3000);
    chk("midstall pcE", pcE, 32'h3000);
    chk("midstall pcM", pcM, 32'h3000);
    chk("midstall pcW", pcW, 32'h3000);
    chk("midstall tnew", {28'd0, tnewE, tnewM}, 32'd0);
    @(posedge clk);
    #1;
    chk("held instrD", instrD, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first instrD", instrD, I_LW1);
    chk("first pcD", pcD, 32'h3000);
    chk("first instrE", instrE, 32'h0);
    @(negedge clk);
    reset_n = 1'b0;

    // lw $1 ; addu $2,$1,$1 : one stall
    load(I_LW1, I_ADDU211, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(1, 2, 0); push_c(0, 0, 1);
    push_c(0, 1, 0); push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_LW1, 32'h3000); push_r(I_ADDU211, 32'h3004);
    run_test("lw_addu");

    // lw $1 ; beq $1,$0 : two stalls
    load(I_LW1, I_BEQ10, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(1, 2, 0); push_c(1, 0, 1);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_LW1, 32'h3000); push_r(I_BEQ10, 32'h3004);
    run_test("lw_beq");

    // ori $3 ; jr $3 ; addu $4,$3,$0 : one stall on jr
    load(I_ORI3, I_JR3, I_ADDU430);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(1, 1, 0); push_c(0, 0, 0);
    push_c(0, 0, 0); push_c(0, 1, 0); push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_ORI3, 32'h3000); push_r(I_JR3, 32'h3004); push_r(I_ADDU430, 32'h3008);
    run_test("ori_jr");

    // ori $3 ; addu $4,$3,$0 : no stall
    load(I_ORI3, I_ADDU430, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 1, 0); push_c(0, 1, 0);
    push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_ORI3, 32'h3000); push_r(I_ADDU430, 32'h3004);
    run_test("ori_addu");

    // lw $0 ; addu $2,$0,$0 : $0 exempt
    load(I_LW0, I_ADDU200, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 2, 0); push_c(0, 1, 1);
    push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_LW0, 32'h3000); push_r(I_ADDU200, 32'h3004);
    run_test("lw0_addu");

    // lw $5 ; sw $5,0($6) : Tuse_rt 2 covers Tnew 2
    load(I_LW5, I_SW56, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 2, 0); push_c(0, 0, 1);
    push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_LW5, 32'h3000); push_r(I_SW56, 32'h3004);
    run_test("lw_sw");

    // jal ; jr $31 in delay slot : no stall
    load(I_JAL, I_JR31, 32'h0);
    push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 0, 0); push_c(0, 0, 0);
    push_c(0, 0, 0); push_c(0, 0, 0);
    push_r(I_JAL, 32'h3000); push_r(I_JR31, 32'h3004);
    run_test("jal_jr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_ctrl.md
Name: hazard_pipe_ctrl

Overview:
- Pipeline-tracking and stall controller for the 5-stage MIPS core (addu, subu, ori, lui, lw, sw, jal, jr, beq; delay slot architectural, no flush).
- Registers the instruction and PC through the D, E, M and W stages. Feeds instrD/E/M/W and pcD..pcW to the forwarding unit and the datapath muxes.
- Detects unresolvable RAW hazards with Tuse/Tnew, then freezes F/D and injects a bubble into E.

Parameters:
- PC_INIT, 32'h0000_3000, reset value of every pc register.
- NOP, 32'h0000_0000, instruction word used for reset and bubbles.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- instrF  in  32  instruction fetched this cycle
- pcF  in  32  PC of instrF
- stall  out  1  combinational; 1 = hold PC and D, bubble E
- pc_en  out  1  ~stall, write enable for the PC register
- instrD, instrE, instrM, instrW  out  32 each  stage instruction registers
- pcD, pcE, pcM, pcW  out  32 each  stage PC registers
- tnewE, tnewM  out  2 each  remaining cycles until the stage result is ready

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values: all instr* = NOP, all pc* = PC_INIT, tnewE = tnewM = 0, stall = 0, pc_en = 1.
- Decode, combinational. Per instruction, derive a3 (destination register), tuse_rs, tuse_rt and tnew0 (Tnew on entry to E):
  - addu/subu: a3 = rd, tuse_rs = 1, tuse_rt = 1, tnew0 = 1
  - ori: a3 = rt, tuse_rs = 1, tnew0 = 1
  - lw: a3 = rt, tuse_rs = 1, tnew0 = 2
  - lui: a3 = rt, tnew0 = 0
  - jal: a3 = 31, tnew0 = 0
  - sw: a3 = 0, tuse_rs = 1, tuse_rt = 2
  - beq: tuse_rs = 0, tuse_rt = 0
  - jr: tuse_rs = 0
  - Unused tuse = 3 (never stalls). Unknown opcodes decode as NOP (a3 = 0).
- Tnew tracking, registered:
  - tnewE loads tnew0(instrD).
  - tnewM loads max(tnewE − 1, 0).
  - W needs no counter; its Tnew is always 0.
- stall = (rs_D ≠ 0 and rs_D = a3X and tnewX > tuse_rs), OR the same test for rt_D with tuse_rt, for X ∈ {E, M}. Never stall on a match in W.
- Normal cycle (stall = 0): D ← F, E ← D, M ← E, W ← M, for both instr and pc. Tnew advances as above.
- Stall cycle (stall = 1):
  - D holds (instrD, pcD unchanged); pc_en = 0.
  - instrE ← NOP and tnewE ← 0.
  - pcE ← pcD, so the bubble keeps a valid PC.
  - M and W advance normally.
- Latency: an instruction that never stalls reaches W 3 cycles after entering D.
- Consecutive stalls: stall re-evaluates every cycle; lw followed by beq on the same register stalls exactly 2 cycles.
- Simultaneous matches in E and M: stall if either requires it. A match in E takes priority only for data correctness, which is the forwarding unit's job, not this block's.
- Register $0 never causes a stall, even if a3 = 0 matches.
- Reset mid-stall: asynchronous clear to reset values immediately; stall drops with the cleared registers.

Decomposition:
- Shared package holds:
  - opcode/funct constants for all nine instructions;
  - field bit ranges (op, func, rs, rt, rd);
  - TUSE_NONE = 3;
  - NOP.
- One sub-module, instr_decode_t: purely combinational, mapping a 32-bit instruction to a3, tuse_rs, tuse_rt, tnew0. It is instantiated for D, E and M.

Test Plan:
- Reset: hold reset_n = 0 mid-run, then release → all instr* = 0, pc* = 32'h3000, stall = 0; first instrF appears on instrD after one edge.
- lw $1,0($0) then addu $2,$1,$1 → stall = 1 for exactly one cycle; instrE = 0 that cycle; addu reaches W 5 cycles after lw entered D.
- lw $1 then beq $1,$0 → stall for 2 consecutive cycles; tnewE = 2 then tnewM = 1 at the stalls; pc_en = 0 both cycles; pcD constant.
- ori $3,$0,5 then jr $3 → one stall cycle (tnewE = 1 > 0). addu $4,$3,$0 after ori → no stall.
- lw $0,0($0) then addu $2,$0,$0 → no stall ($0 exempt). lw $5 then sw $5,0($6) → no stall (tuse_rt = 2 ≥ tnew 2).
- jal then jr $31 in the delay slot → no stall (tnew0 = 0); instrW sequence = jal, jr with pcW = 32'h3000, 32'h3004.
